// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Optional statistics counters are enabled by defining PRED_STATS_EN.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    localparam bp_ctr_t BP_RESET_CTR = WNT;

    // Saturating increment: strongly-taken stays strongly-taken
    function automatic bp_ctr_t sat_inc(input bp_ctr_t c);
        return (c == ST) ? ST : bp_ctr_t'(c + 2'd1);
    endfunction

    // Saturating decrement: strongly-not-taken stays strongly-not-taken
    function automatic bp_ctr_t sat_dec(input bp_ctr_t c);
        return (c == SNT) ? SNT : bp_ctr_t'(c - 2'd1);
    endfunction

    // Table index: word-address bits just above the byte offset
    function automatic logic [63:0] bp_idx(input logic [63:0] pc, input int idxw);
        return (pc >> 2) & ((64'd1 << idxw) - 64'd1);
    endfunction

    // Tag: every PC bit above the index
    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int idxw);
        return pc >> (idxw + 2);
    endfunction

endpackage

// File: rtl/bp_if.sv
// Fetch/execute connection between the pipeline and the branch predictor.
// Statistics outputs exist only when PRED_STATS_EN is defined.
interface bp_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] PCF;
    logic            predTakenF;
    logic [XLEN-1:0] predTargetF;
    logic            updateE;
    logic [XLEN-1:0] PCE;
    logic            branchTakenE;
    logic [XLEN-1:0] targetE;
    logic            predTakenE;
`ifdef PRED_STATS_EN
    logic [31:0]     predCount;
    logic [31:0]     mispredCount;
`endif

    // Pipeline side: issues fetch PCs and resolved branches
    modport master (
`ifdef PRED_STATS_EN
        input  predCount,
        input  mispredCount,
`endif
        output PCF,
        input  predTakenF,
        input  predTargetF,
        output updateE,
        output PCE,
        output branchTakenE,
        output targetE,
        output predTakenE
    );

    // Predictor side
    modport slave (
`ifdef PRED_STATS_EN
        output predCount,
        output mispredCount,
`endif
        input  PCF,
        output predTakenF,
        output predTargetF,
        input  updateE,
        input  PCE,
        input  branchTakenE,
        input  targetE,
        input  predTakenE
    );

endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target storage.
// Two async read ports (fetch lookup, execute hit check), one sync write port.
module bp_btb #(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32,
    parameter int IDXW    = $clog2(ENTRIES),
    parameter int TAGW    = XLEN - IDXW - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IDXW-1:0] idx_f,
    input  logic [TAGW-1:0] tag_f,
    output logic            hit_f,
    output logic [XLEN-1:0] target_f,
    input  logic [IDXW-1:0] idx_e,
    input  logic [TAGW-1:0] tag_e,
    output logic            hit_e,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_target
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    // Valid bits clear asynchronously; a write marks the entry live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[idx_e] <= 1'b1;
        end
    end

    // Tag/target payload carries no reset; valid gates every use of it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= wr_target;
        end
    end

    // Lookups read the pre-write contents; no write-to-read bypass
    always_comb begin
        hit_f    = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
        target_f = target_q[idx_f];
        hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction/target predictor: direct-mapped BTB plus one
// 2-bit saturating counter per entry, trained by resolved EX outcomes.
// Define PRED_STATS_EN to build the prediction/mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int XLEN    = 32
) (
    input  logic clk,
    input  logic rst_n,
    bp_if.slave  bus
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [IDXW-1:0] idx_f;
    logic [IDXW-1:0] idx_e;
    logic [TAGW-1:0] tag_f;
    logic [TAGW-1:0] tag_e;
    logic            hit_f;
    logic            hit_e;
    logic [XLEN-1:0] btb_target_f;
    logic            pred_taken_f;
    logic            btb_wr;
    bp_ctr_t         ctr_q [ENTRIES];

    assign idx_f = IDXW'(bp_idx(64'(bus.PCF), IDXW));
    assign tag_f = TAGW'(bp_tag(64'(bus.PCF), IDXW));
    assign idx_e = IDXW'(bp_idx(64'(bus.PCE), IDXW));
    assign tag_e = TAGW'(bp_tag(64'(bus.PCE), IDXW));

    // Any taken outcome writes target (hit) or allocates/replaces (miss);
    // not-taken never touches the BTB, so an alias only evicts when taken.
    assign btb_wr = bus.updateE && bus.branchTakenE;

    bp_btb #(
        .ENTRIES (ENTRIES),
        .XLEN    (XLEN),
        .IDXW    (IDXW),
        .TAGW    (TAGW)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx_f     (idx_f),
        .tag_f     (tag_f),
        .hit_f     (hit_f),
        .target_f  (btb_target_f),
        .idx_e     (idx_e),
        .tag_e     (tag_e),
        .hit_e     (hit_e),
        .wr_en     (btb_wr),
        .wr_target (bus.targetE)
    );

    // Counter training: move on a hit, seed weakly-taken on a taken miss
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= BP_RESET_CTR;
            end
        end else if (bus.updateE) begin
            if (hit_e) begin
                ctr_q[idx_e] <= bus.branchTakenE ? sat_inc(ctr_q[idx_e])
                                                 : sat_dec(ctr_q[idx_e]);
            end else if (bus.branchTakenE) begin
                ctr_q[idx_e] <= WT;
            end
        end
    end

    // Zero-latency prediction; fall-through PC wraps naturally at XLEN bits
    always_comb begin
        pred_taken_f    = hit_f && (ctr_q[idx_f] inside {WT, ST});
        bus.predTakenF  = pred_taken_f;
        bus.predTargetF = pred_taken_f ? btb_target_f : (bus.PCF + XLEN'(4));
    end

`ifdef PRED_STATS_EN
    logic [31:0] pred_cnt_q;
    logic [31:0] mispred_cnt_q;

    // Resolved-branch and direction-mispredict counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_cnt_q    <= '0;
            mispred_cnt_q <= '0;
        end else if (bus.updateE) begin
            pred_cnt_q <= pred_cnt_q + 32'd1;
            if (bus.predTakenE != bus.branchTakenE) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bus.predCount    = pred_cnt_q;
    assign bus.mispredCount = mispred_cnt_q;
`else
    // The piped-through prediction only feeds the statistics
    logic unused_pred_taken_e;
    assign unused_pred_taken_e = bus.predTakenE;
`endif

endmodule
